// File: rtl/buf_mem_loader_pkg.sv
// Shared types and helpers for the buffer-memory preload stage.
package buf_mem_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWrite,
        StDone
    } loader_state_e;

    function automatic int unsigned beats_per_word(input int unsigned lanes,
                                                   input int unsigned width,
                                                   input int unsigned in_width);
        return (lanes * width) / in_width;
    endfunction

endpackage

// File: rtl/buf_mem_loader_beat_packer.sv
// Packs BEATS stream beats of IN_WIDTH bits into one word; the first beat lands in the LSBs.
module buf_mem_loader_beat_packer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned BEATS    = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      clr_i,
    input  logic                      push_i,
    input  logic [IN_WIDTH-1:0]       data_i,
    output logic [BEATS*IN_WIDTH-1:0] word_o,
    output logic                      full_o
);

    localparam int unsigned WordW = BEATS * IN_WIDTH;
    localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WordW-1:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (push_i) begin
            word_d[cnt_q*IN_WIDTH +: IN_WIDTH] = data_i;
            cnt_d = (cnt_q == LastBeat) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
    assign full_o = push_i && !clr_i && (cnt_q == LastBeat);

endmodule

// File: rtl/buf_mem_loader.sv
// Packs a narrow valid/ready byte stream into LANES*WIDTH words and writes them to an SRAM port.
// Optional XOR checksum of the written words: define BUF_MEM_LOADER_CHECKSUM_EN.
module buf_mem_loader
    import buf_mem_loader_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LANES    = 4,
    parameter int unsigned SIZE     = 256,
    parameter int unsigned IN_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     start_i,
    input  logic [$clog2(SIZE)-1:0]  base_addr_i,
    input  logic [$clog2(SIZE):0]    num_words_i,
    input  logic                     s_valid_i,
    input  logic [IN_WIDTH-1:0]      s_data_i,
    output logic                     s_ready_o,
    output logic                     mem_cenb_o,
    output logic                     mem_wenb_o,
    output logic [$clog2(SIZE)-1:0]  mem_addr_o,
    output logic [LANES*WIDTH-1:0]   mem_d_o,
`ifdef BUF_MEM_LOADER_CHECKSUM_EN
    output logic [LANES*WIDTH-1:0]   checksum_o,
`endif
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned DataW = LANES * WIDTH;
    localparam int unsigned AddrW = $clog2(SIZE);
    localparam int unsigned Beats = beats_per_word(LANES, WIDTH, IN_WIDTH);

    if (Beats * IN_WIDTH != DataW) begin : g_bad_in_width
        $error("IN_WIDTH must evenly divide LANES*WIDTH");
    end

    loader_state_e    state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [AddrW:0]   cnt_q, cnt_d;
    logic [AddrW-1:0] mem_addr_q, mem_addr_d;
    logic [DataW-1:0] mem_d_q, mem_d_d;

    logic             pack_clr;
    logic             pack_push;
    logic             pack_full;
    logic [DataW-1:0] pack_word;

    assign pack_push = s_valid_i && s_ready_o;

    buf_mem_loader_beat_packer #(
        .IN_WIDTH (IN_WIDTH),
        .BEATS    (Beats)
    ) u_packer (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (pack_clr),
        .push_i (pack_push),
        .data_i (s_data_i),
        .word_o (pack_word),
        .full_o (pack_full)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = (num_words_i == '0) ? StDone : StFill;
            StFill:  if (pack_full) state_d = StWrite;
            StWrite: state_d = (cnt_q == (AddrW+1)'(1)) ? StDone : StFill;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_ready_o  = 1'b0;
        mem_cenb_o = 1'b1;
        mem_wenb_o = 1'b1;
        mem_addr_o = mem_addr_q;
        mem_d_o    = mem_d_q;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        unique case (state_q)
            StIdle: busy_o = 1'b0;
            StFill: s_ready_o = 1'b1;
            StWrite: begin
                mem_cenb_o = 1'b0;
                mem_wenb_o = 1'b0;
                mem_addr_o = addr_q;
                mem_d_o    = pack_word;
            end
            StDone: done_o = 1'b1;
            default: ;
        endcase
    end

    // Address/word counters; the mem_* hold registers keep the last written word visible.
    always_comb begin
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_d_d    = mem_d_q;
        pack_clr   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d   = base_addr_i;
                    cnt_d    = num_words_i;
                    pack_clr = 1'b1;
                end
            end
            StWrite: begin
                mem_addr_d = addr_q;
                mem_d_d    = pack_word;
                addr_d     = (addr_q == AddrW'(SIZE - 1)) ? '0 : addr_q + AddrW'(1);
                cnt_d      = cnt_q - (AddrW+1)'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_d_q    <= mem_d_d;
        end
    end

`ifdef BUF_MEM_LOADER_CHECKSUM_EN
    logic [DataW-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == StIdle && start_i) begin
            checksum_d = '0;
        end else if (state_q == StWrite) begin
            checksum_d = checksum_q ^ pack_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_buf_mem_loader.sv
// Randomized self-checking bench for buf_mem_loader against a word-level scoreboard.
module tb_buf_mem_loader;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned LANES    = 4;
    localparam int unsigned SIZE     = 256;
    localparam int unsigned IN_WIDTH = 8;
    localparam int unsigned DW       = LANES * WIDTH;
    localparam int unsigned AW       = $clog2(SIZE);
    localparam int unsigned BEATS    = DW / IN_WIDTH;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                start = 1'b0;
    logic [AW-1:0]       base_addr = '0;
    logic [AW:0]         num_words = '0;
    logic                s_valid = 1'b0;
    logic [IN_WIDTH-1:0] s_data = '0;
    logic                s_ready;
    logic                mem_cenb;
    logic                mem_wenb;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_d;
    logic                busy;
    logic                done;
`ifdef BUF_MEM_LOADER_CHECKSUM_EN
    logic [DW-1:0]       checksum;
`endif

    buf_mem_loader #(
        .WIDTH    (WIDTH),
        .LANES    (LANES),
        .SIZE     (SIZE),
        .IN_WIDTH (IN_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start),
        .base_addr_i (base_addr),
        .num_words_i (num_words),
        .s_valid_i   (s_valid),
        .s_data_i    (s_data),
        .s_ready_o   (s_ready),
        .mem_cenb_o  (mem_cenb),
        .mem_wenb_o  (mem_wenb),
        .mem_addr_o  (mem_addr),
        .mem_d_o     (mem_d),
`ifdef BUF_MEM_LOADER_CHECKSUM_EN
        .checksum_o  (checksum),
`endif
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: writes still owed by the current load, and a log of writes seen.
    logic [AW-1:0]       exp_addr_q[$];
    logic [DW-1:0]       exp_data_q[$];
    logic [DW-1:0]       exp_sum;
    int                  exp_done_cyc = -1;
    logic [AW-1:0]       wr_addr_log[$];
    logic [DW-1:0]       wr_data_log[$];
    int                  wr_cyc_log[$];
    logic [IN_WIDTH-1:0] beats_q[$];
    bit                  pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (!mem_cenb) begin
                wr_addr_log.push_back(mem_addr);
                wr_data_log.push_back(mem_d);
                wr_cyc_log.push_back(cyc);
                check("wenb_on_write", 64'(mem_wenb), 64'(0));
                if (exp_addr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got write addr=%0h data=%0h, expected none",
                             mem_addr, mem_d);
                end else begin
                    check("wr_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                    check("wr_data", 64'(mem_d), 64'(exp_data_q.pop_front()));
                    if (exp_addr_q.size() == 0) exp_done_cyc = cyc + 1;
                end
            end
            check("done", 64'(done), 64'(cyc == exp_done_cyc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [IN_WIDTH-1:0] d);
        int n = 0;
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = s_ready;
            tick();
            n++;
        end
        s_valid = 1'b0;
        if (!ok) check("beat_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        if (!done) check("done_timeout", 64'(0), 64'(1));
        tick();
    endtask

    // mode 0: continuous beats, 1: random gaps, 2: fixed valid pattern 1,0,0,1,1,0,1.
    task automatic run_load(input logic [AW-1:0] b, input int n, input int mode,
                            input bit busy_start);
        logic [DW-1:0] w;
        int gi = 0;
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_cyc_log.delete();
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            w = '0;
            for (int j = 0; j < int'(BEATS); j++) w[j*IN_WIDTH +: IN_WIDTH] = beats_q[i*BEATS+j];
            exp_addr_q.push_back(AW'((int'(b) + i) % SIZE));
            exp_data_q.push_back(w);
            exp_sum ^= w;
        end
        start     = 1'b1;
        base_addr = b;
        num_words = (AW+1)'(n);
        if (n == 0) exp_done_cyc = cyc + 1;
        tick();
        start = 1'b0;
        for (int k = 0; k < n * int'(BEATS); k++) begin
            if (mode == 1) while ($urandom_range(0, 2) == 0) tick();
            if (mode == 2) begin
                while (gi < 7 && pat[gi] == 1'b0) begin
                    gi++;
                    tick();
                end
                gi++;
            end
            if (busy_start && k == 1) begin
                start     = 1'b1;
                base_addr = ~b;
                num_words = (AW+1)'(3);
            end
            send_beat(beats_q[k]);
            start = 1'b0;
        end
        wait_done();
        check("writes_outstanding", 64'(exp_addr_q.size()), 64'(0));
        check("writes_logged", 64'(wr_addr_log.size()), 64'(n));
`ifdef BUF_MEM_LOADER_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(exp_sum));
`endif
    endtask

    task automatic check_log(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (wr_addr_log.size() <= idx) begin
            check("log_missing_write", 64'(wr_addr_log.size()), 64'(idx + 1));
        end else begin
            check("log_addr", 64'(wr_addr_log[idx]), 64'(a));
            check("log_data", 64'(wr_data_log[idx]), 64'(d));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_cenb", 64'(mem_cenb), 64'(1));
        check("rst_wenb", 64'(mem_wenb), 64'(1));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_data", 64'(mem_d), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
`ifdef BUF_MEM_LOADER_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'(0));
`endif
    endtask

    task automatic fill_beats(input int n, input bit rnd, input int first);
        beats_q.delete();
        for (int i = 0; i < n; i++) begin
            beats_q.push_back(rnd ? IN_WIDTH'($urandom) : IN_WIDTH'(first + i));
        end
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rstn = 1'b1;
        tick();

        // Basic two-word load.
        fill_beats(8, 1'b0, 1);
        run_load(AW'(5), 2, 0, 1'b0);
        check_log(0, AW'(5), DW'(32'h0403_0201));
        check_log(1, AW'(6), DW'(32'h0807_0605));
        if (wr_cyc_log.size() == 2) begin
            check("word_spacing", 64'(wr_cyc_log[1] - wr_cyc_log[0]), 64'(BEATS + 1));
        end
`ifdef BUF_MEM_LOADER_CHECKSUM_EN
        check("checksum_basic", 64'(checksum), 64'(32'h0C04_0404));
`endif

        // Address wrap.
        fill_beats(8, 1'b1, 0);
        run_load(AW'(255), 2, 0, 1'b0);
        if (wr_addr_log.size() == 2) begin
            check("wrap_addr0", 64'(wr_addr_log[0]), 64'(255));
            check("wrap_addr1", 64'(wr_addr_log[1]), 64'(0));
        end

        // Zero length: done one cycle after start, no write.
        beats_q.delete();
        run_load(AW'(3), 0, 0, 1'b0);

        // Backpressure gaps give the same word as the continuous case.
        fill_beats(4, 1'b0, 1);
        run_load(AW'(20), 1, 2, 1'b0);
        check_log(0, AW'(20), DW'(32'h0403_0201));

        // Start pulse during FILL is ignored.
        fill_beats(8, 1'b1, 0);
        run_load(AW'(40), 2, 0, 1'b1);
        if (wr_addr_log.size() == 2) begin
            check("busy_addr0", 64'(wr_addr_log[0]), 64'(40));
            check("busy_addr1", 64'(wr_addr_log[1]), 64'(41));
        end

        for (int r = 0; r < 10; r++) begin
            int n;
            n = int'($urandom_range(0, 4));
            fill_beats(n * BEATS, 1'b1, 0);
            run_load(AW'($urandom), n, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset after two beats aborts the load without a write.
        exp_addr_q.delete();
        exp_data_q.delete();
        start     = 1'b1;
        base_addr = AW'(7);
        num_words = (AW+1)'(1);
        tick();
        start = 1'b0;
        send_beat(8'h11);
        send_beat(8'h22);
        rstn = 1'b0;
        tick();
        check_reset_outputs();
        rstn = 1'b1;
        exp_done_cyc = -1;
        tick();
        fill_beats(4, 1'b0, 8'hA1);
        run_load(AW'(9), 1, 0, 1'b0);
        check_log(0, AW'(9), DW'(32'hA4A3_A2A1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/buf_mem_loader.md
Name: buf_mem_loader

Overview:
- Upstream preload stage for the input, weight and partial-sum buffer memories that feed matrix_mult_wrapper.
- Accepts a narrow DRIVER_WIDTH-style byte stream over a valid/ready handshake and packs it into full LANES*WIDTH memory words.
- Writes each packed word to consecutive addresses through the active-low cenb/wenb SRAM port used by mem_emulator.
- One instance per buffer, muxed onto the memory in place of the ext_* control signals.

Parameters:
- WIDTH, 8, bits per lane element (matches matrix_mult_pkg::WIDTH).
- LANES, 4, elements per memory word (ROW for the input buffer, COL for the weight/psum buffers).
- SIZE, 256, memory depth in words.
- IN_WIDTH, 8, stream beat width. LANES*WIDTH must be an integer multiple of IN_WIDTH; elaboration fails otherwise.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rstn_i  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle pulse; sampled only in IDLE.
- base_addr_i  in  $clog2(SIZE)  first write address; latched on start.
- num_words_i  in  $clog2(SIZE)+1  number of words to write; latched on start.
- s_valid_i  in  1  stream beat valid.
- s_data_i  in  IN_WIDTH  stream beat data.
- s_ready_o  out  1  loader accepts a beat.
- mem_cenb_o  out  1  memory chip enable, active-low.
- mem_wenb_o  out  1  memory write enable, active-low.
- mem_addr_o  out  $clog2(SIZE)  memory address.
- mem_d_o  out  LANES*WIDTH  memory write data.
- busy_o  out  1  high in every state other than IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Derived constant: BEATS = LANES*WIDTH/IN_WIDTH.
- States: IDLE, FILL, WRITE, DONE.
- Reset (rstn_i=0 at a clock edge): state=IDLE; s_ready_o=0; mem_cenb_o=1; mem_wenb_o=1; mem_addr_o=0; mem_d_o=0; busy_o=0; done_o=0; beat counter, word counter and pack register cleared.
- Reset mid-operation aborts the load immediately. A partially packed word is never written.
- IDLE:
  - start_i with num_words_i=0 → DONE; no memory access.
  - start_i with num_words_i>0 → latch base address and word count, clear the pack register → FILL.
- FILL:
  - s_ready_o=1.
  - Each s_valid_i&s_ready_o beat lands in slice [beat*IN_WIDTH +: IN_WIDTH], so the first beat occupies the LSBs.
  - Gaps in s_valid_i stall without side effects.
  - Accepting beat BEATS-1 → WRITE.
- WRITE (exactly one cycle):
  - s_ready_o=0; mem_cenb_o=0; mem_wenb_o=0; mem_addr_o = current address; mem_d_o = packed word.
  - Then address increments modulo SIZE (SIZE-1 wraps to 0) and word count decrements.
  - If count reaches 0 → DONE, else → FILL.
- DONE: done_o=1 for one cycle → IDLE.
- Outside WRITE: mem_cenb_o=1 and mem_wenb_o=1; mem_addr_o and mem_d_o hold their last values.
- start_i while busy_o=1 is ignored.
- Throughput: BEATS+1 cycles per word under continuous valid.
- Latency: done_o is asserted in the cycle immediately after the final WRITE.

Optional Feature:
- Macro: BUF_MEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum_o, LANES*WIDTH wide.
  - checksum_o is the XOR of every word written in the current load.
  - Cleared on an accepted start; updated in each WRITE cycle.
  - Valid when done_o is high and held until the next start.
  - Reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- matrix_mult_pkg additions:
  - typedef loader_state_e {IDLE, FILL, WRITE, DONE}.
  - Function beats_per_word(lanes, width, in_width).
- Sub-module beat_packer:
  - Shift/insert register plus beat counter.
  - Outputs word_o and full_o.
  - Controlled by clr_i and push_i.
- The FSM and address/word counters stay in buf_mem_loader.

Test Plan (LANES=4, WIDTH=8, IN_WIDTH=8, SIZE=256):
- Basic load:
  - Stimulus: start with base=5, num=2; continuous beats 0x01..0x08.
  - Response: write mem[5]=0x04030201, then mem[6]=0x08070605, 5 cycles apart.
  - done_o asserts one cycle after the second write.
  - With BUF_MEM_LOADER_CHECKSUM_EN, checksum_o=0x0C040404.
- Wrap-around:
  - Stimulus: base=255, num=2.
  - Response: writes to addresses 255 then 0; nothing written at 256.
- Zero length:
  - Stimulus: num=0.
  - Response: done_o one cycle after start; mem_cenb_o stays 1 throughout.
- Backpressure gaps:
  - Stimulus: s_valid_i toggled 1,0,0,1,1,0,1.
  - Response: the word is written only after the 4th accepted beat, with data unchanged from the continuous case.
- Start while busy:
  - Stimulus: second start_i pulse during FILL.
  - Response: ignored; write count and addresses unchanged.
- Reset mid-fill:
  - Stimulus: rstn_i low after 2 beats.
  - Response: state IDLE, no write issued, all outputs at reset values.
  - A following load of 1 word writes only the new 4 beats.
